keypad_operand_entry: RTL and testbench
=======================================

Name: keypad_operand_entry

Overview:
- Operand-entry front end for the calculator, the input counterpart of the result display path.
- Scans a 4x4 matrix keypad, debounces presses and decodes keys.
- Accumulates up to three decimal digits into an 8-bit binary operand and presents it with a one-cycle valid pulse for the adder datapath.
- `entry` is exported live so the FND controller can echo digits while they are typed.

Parameters:
SCAN_DIV, 100000, clocks per scan tick (1 ms at 100 MHz); must be >= 2
DEBOUNCE_TICKS, 4, consecutive confirming scan ticks required for press and release; must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
key_row  output  4  row drive, active-low one-hot
key_col  input  4  column sense, active-low (external pull-ups)
key_valid  output  1  one-cycle pulse on each debounced press
key_code  output  4  code of the last debounced key
entry  output  8  operand being typed (binary)
digit_count  output  2  digits currently in entry (0..3)
operand  output  8  last committed operand
operand_valid  output  1  one-cycle pulse when operand is committed
entry_err  output  1  one-cycle pulse on a rejected digit

Behaviour:
- One clock (clk). Reset is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values:
  - key_row = 4'b1110, row_idx = 0, divider = 0, FSM = SCAN.
  - All other outputs = 0. Debounce counter = 0.
  - Reset asserted in any state, including mid-debounce or while a key is held, overrides everything on that edge.
- Tick generation: divider counts 0..SCAN_DIV-1. tick = (divider == SCAN_DIV-1), then the divider wraps to 0.
- key_row = ~(1 << row_idx). key_col is sampled only on tick. Active column = lowest-index 0 bit of key_col.
- Key map (row, col -> key_code):
  - r0: 1, 2, 3, A(10)
  - r1: 4, 5, 6, B(11)
  - r2: 7, 8, 9, C(12)
  - r3: *(14), 0, #(15), D(13)
- FSM:
  - SCAN: on tick, if any col is low, latch row_idx and active col, set cnt = 0, go to DEBOUNCE with the row held. Otherwise row_idx = row_idx + 1 mod 4.
  - DEBOUNCE: on tick, if the latched col is still low, cnt++. When cnt reaches DEBOUNCE_TICKS, go to PRESSED. If the latched col is high, go to SCAN and advance row_idx.
  - On entering PRESSED, in the same clock: key_valid = 1, key_code is updated, and the key action below executes.
  - PRESSED: row stays held. On tick, if the latched col is high, set cnt = 0 and go to RELEASE.
  - RELEASE: on tick, if col is high, cnt++. When cnt reaches DEBOUNCE_TICKS, go to SCAN and advance row_idx. If col is low, go to PRESSED with no new key_valid.
- Only one key is tracked at a time. Other keys in the held row are ignored until return to SCAN.
- Key actions:
  - Digit d: compute nxt = entry*10 + d at >= 12-bit width.
    - If digit_count == 3 or nxt > 255: entry is unchanged and entry_err pulses.
    - Else: entry = nxt[7:0], digit_count++.
  - '#': if digit_count != 0, then operand = entry, operand_valid pulses, entry = 0, digit_count = 0. If digit_count == 0, no effect.
  - '*': entry = 0, digit_count = 0. operand is unchanged, no pulse.
  - A-D: key_valid/key_code only. entry is unchanged.
- Pulse rules:
  - key_valid, operand_valid and entry_err are high for exactly one clk.
  - operand_valid and entry_err are coincident with key_valid.
  - operand holds its value until the next commit.
- Latency: key_valid rises exactly DEBOUNCE_TICKS ticks after the detection tick, with no bounce.

Test Plan (SCAN_DIV=4, DEBOUNCE_TICKS=3; the bench models the keypad so that key_col pulls low the pressed column when its row is driven low):
1. Reset, no key pressed:
   - Outputs are 0 and key_row = 1110.
   - key_row then rotates 1101, 1011, 0111, 1110, changing every 4 clk.
2. Press/release '1', '2', '8', '#':
   - entry goes 1, 12, 128 and digit_count goes 1, 2, 3.
   - On '#': operand = 128 with a 1-clk operand_valid, entry = 0, digit_count = 0.
3. Keys '2', '5', '6':
   - '6' is rejected (256 > 255): entry_err pulses, entry stays 25.
   - '#' then commits operand = 25.
4. Bounce and hold on '5':
   - Press held low for 2 ticks, then released: no key_valid; SCAN resumes with the row advancing.
   - Press held 50 ticks, including a 1-tick release glitch: exactly one key_valid with key_code = 5.
5. Clear and ignored keys:
   - '9', '9', '*': entry = 0, no operand_valid.
   - '#' on an empty entry: no pulse.
   - 'A': key_valid with key_code = 10, entry unchanged.
6. Reset mid-operation:
   - Reset asserted for one clk while in PRESSED with entry = 7: all outputs return to reset values on the next edge.
   - The still-held key is re-detected after the debounce period and produces a fresh key_valid and entry update.

Source files
------------

// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: scans a 4x4 active-low matrix keypad, debounces a
// single key at a time, decodes it and builds a decimal operand (max three
// digits, max 255) that is committed with '#' and cleared with '*'.
//
// state    | meaning
// ---------+------------------------------------------------------------
// SCAN     | rotating the row drive, looking for any low column
// DEBOUNCE | row held, counting ticks the latched column stays low
// PRESSED  | key accepted and acted on, waiting for the column to rise
// RELEASE  | row held, counting ticks the latched column stays high
module keypad_operand_entry #(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] key_row,
   input  logic [3:0] key_col,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic [7:0] entry,
   output logic [1:0] digit_count,
   output logic [7:0] operand,
   output logic       operand_valid,
   output logic       entry_err
);

   localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

   localparam logic [3:0] CODE_STAR = 4'd14;
   localparam logic [3:0] CODE_HASH = 4'd15;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       row_q, row_d;
   logic [1:0]       col_q, col_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       key_valid_q, key_valid_d;
   logic [3:0] key_code_q, key_code_d;
   logic [7:0] entry_q, entry_d;
   logic [1:0] digit_count_q, digit_count_d;
   logic [7:0] operand_q, operand_d;
   logic       operand_valid_q, operand_valid_d;
   logic       entry_err_q, entry_err_d;

   logic        tick;
   logic        any_low;
   logic        col_low;
   logic        enter_pressed;
   logic [3:0]  code_new;
   logic [11:0] nxt_wide;

   // Lowest-index column that is pulled low; only meaningful when one is.
   function automatic logic [1:0] lowest_low(input logic [3:0] col);
      logic [1:0] idx;
      idx = 2'd3;
      if (!col[2]) idx = 2'd2;
      if (!col[1]) idx = 2'd1;
      if (!col[0]) idx = 2'd0;
      return idx;
   endfunction

   // Physical position to key code; '*' and '#' sit either side of '0'.
   function automatic logic [3:0] decode_key(input logic [1:0] row,
                                             input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'b00_00: code = 4'd1;
         4'b00_01: code = 4'd2;
         4'b00_10: code = 4'd3;
         4'b00_11: code = 4'd10;
         4'b01_00: code = 4'd4;
         4'b01_01: code = 4'd5;
         4'b01_10: code = 4'd6;
         4'b01_11: code = 4'd11;
         4'b10_00: code = 4'd7;
         4'b10_01: code = 4'd8;
         4'b10_10: code = 4'd9;
         4'b10_11: code = 4'd12;
         4'b11_00: code = CODE_STAR;
         4'b11_01: code = 4'd0;
         4'b11_10: code = CODE_HASH;
         default:  code = 4'd13;
      endcase
      return code;
   endfunction

   assign tick     = (div_q == DIV_LAST);
   assign any_low  = (key_col != 4'b1111);
   assign col_low  = ~key_col[col_q];
   assign code_new = decode_key(row_q, col_q);
   // Wide enough that 255*10+9 cannot wrap before the range check.
   assign nxt_wide = 12'(entry_q) * 12'd10 + 12'(code_new);

   assign key_row       = ~(4'b0001 << row_q);
   assign key_valid     = key_valid_q;
   assign key_code      = key_code_q;
   assign entry         = entry_q;
   assign digit_count   = digit_count_q;
   assign operand       = operand_q;
   assign operand_valid = operand_valid_q;
   assign entry_err     = entry_err_q;

   // Scan-tick divider: free-running 0..SCAN_DIV-1.
   always_comb begin
      div_d = div_q + 1'b1;
      if (tick) div_d = '0;
   end

   // Scan/debounce sequencing; state only moves on scan ticks.
   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      col_d         = col_q;
      cnt_d         = cnt_q;
      enter_pressed = 1'b0;
      case (state_q)
         ST_SCAN: begin
            if (tick) begin
               if (any_low) begin
                  col_d   = lowest_low(key_col);
                  cnt_d   = '0;
                  state_d = ST_DEBOUNCE;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         ST_DEBOUNCE: begin
            if (tick) begin
               if (col_low) begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     state_d       = ST_PRESSED;
                     enter_pressed = 1'b1;
                  end
               end else begin
                  state_d = ST_SCAN;
                  row_d   = row_q + 1'b1;
               end
            end
         end
         ST_PRESSED: begin
            if (tick && !col_low) begin
               cnt_d   = '0;
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (tick) begin
               if (!col_low) begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     state_d = ST_SCAN;
                     row_d   = row_q + 1'b1;
                  end
               end else begin
                  // Bounce back to low is the same press; no new key_valid.
                  state_d = ST_PRESSED;
               end
            end
         end
         default: state_d = ST_SCAN;
      endcase
   end

   // Key action, executed once on the edge that enters PRESSED.
   always_comb begin
      key_valid_d     = 1'b0;
      operand_valid_d = 1'b0;
      entry_err_d     = 1'b0;
      key_code_d      = key_code_q;
      entry_d         = entry_q;
      digit_count_d   = digit_count_q;
      operand_d       = operand_q;
      if (enter_pressed) begin
         key_valid_d = 1'b1;
         key_code_d  = code_new;
         if (code_new <= 4'd9) begin
            if (digit_count_q == 2'd3 || nxt_wide > 12'd255) begin
               entry_err_d = 1'b1;
            end else begin
               entry_d       = nxt_wide[7:0];
               digit_count_d = digit_count_q + 1'b1;
            end
         end else if (code_new == CODE_HASH) begin
            if (digit_count_q != 2'd0) begin
               operand_d       = entry_q;
               operand_valid_d = 1'b1;
               entry_d         = 8'd0;
               digit_count_d   = 2'd0;
            end
         end else if (code_new == CODE_STAR) begin
            entry_d       = 8'd0;
            digit_count_d = 2'd0;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_SCAN;
         div_q           <= '0;
         row_q           <= 2'd0;
         col_q           <= 2'd0;
         cnt_q           <= '0;
         key_valid_q     <= 1'b0;
         key_code_q      <= 4'd0;
         entry_q         <= 8'd0;
         digit_count_q   <= 2'd0;
         operand_q       <= 8'd0;
         operand_valid_q <= 1'b0;
         entry_err_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         div_q           <= div_d;
         row_q           <= row_d;
         col_q           <= col_d;
         cnt_q           <= cnt_d;
         key_valid_q     <= key_valid_d;
         key_code_q      <= key_code_d;
         entry_q         <= entry_d;
         digit_count_q   <= digit_count_d;
         operand_q       <= operand_d;
         operand_valid_q <= operand_valid_d;
         entry_err_q     <= entry_err_d;
      end
   end

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Bench for keypad_operand_entry: models the keypad matrix and checks every
// accepted key against an integer model of the operand-entry rules.
module tb_keypad_operand_entry;

   localparam int SD  = 4;
   localparam int DB  = 3;
   localparam int LAT = SD * (DB + 1);

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] key_row;
   logic [3:0] key_col;
   logic       key_valid;
   logic [3:0] key_code;
   logic [7:0] entry;
   logic [1:0] digit_count;
   logic [7:0] operand;
   logic       operand_valid;
   logic       entry_err;

   logic       held = 1'b0;
   logic [1:0] hrow = 2'd0;
   logic [1:0] hcol = 2'd0;

   int n_assert = 0;
   int n_fail   = 0;
   int kv_count = 0;
   int ov_count = 0;
   int er_count = 0;

   int m_entry   = 0;
   int m_cnt     = 0;
   int m_operand = 0;
   int m_opv     = 0;
   int m_err     = 0;

   int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11},
                         '{7, 8, 9, 12}, '{14, 0, 15, 13}};

   keypad_operand_entry #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DB)) dut (
      .clk(clk), .reset(reset), .key_row(key_row), .key_col(key_col),
      .key_valid(key_valid), .key_code(key_code), .entry(entry),
      .digit_count(digit_count), .operand(operand),
      .operand_valid(operand_valid), .entry_err(entry_err)
   );

   always #5 clk = ~clk;

   // Pressed switch connects its column to its row; pull-ups otherwise.
   assign key_col = (held && key_row[hrow] == 1'b0) ? ~(4'b0001 << hcol) : 4'b1111;

   always @(negedge clk) begin
      if (key_valid === 1'b1)     kv_count++;
      if (operand_valid === 1'b1) ov_count++;
      if (entry_err === 1'b1)     er_count++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_key(input int code);
      m_opv = 0;
      m_err = 0;
      if (code <= 9) begin
         if (m_cnt == 3 || m_entry * 10 + code > 255) m_err = 1;
         else begin
            m_entry = m_entry * 10 + code;
            m_cnt++;
         end
      end else if (code == 15) begin
         if (m_cnt != 0) begin
            m_operand = m_entry;
            m_opv     = 1;
            m_entry   = 0;
            m_cnt     = 0;
         end
      end else if (code == 14) begin
         m_entry = 0;
         m_cnt   = 0;
      end
   endfunction

   task automatic locate(input int code, output logic [1:0] r, output logic [1:0] c);
      r = 2'd0;
      c = 2'd0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (keymap[i][j] == code) begin
               r = 2'(i);
               c = 2'(j);
            end
   endtask

   task automatic wait_row(input logic [1:0] r, input logic lvl);
      int k = 0;
      while (key_row[r] !== lvl && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("row_wait_bound", (k < 200), 1);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (key_valid !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_pulse(input int code);
      model_key(code);
      check("key_valid", key_valid, 1);
      check("key_code", key_code, code);
      check("entry", entry, m_entry);
      check("digit_count", digit_count, m_cnt);
      check("operand", operand, m_operand);
      check("operand_valid", operand_valid, m_opv);
      check("entry_err", entry_err, m_err);
      @(negedge clk);
      check("key_valid_width", key_valid, 0);
      check("operand_valid_width", operand_valid, 0);
      check("entry_err_width", entry_err, 0);
   endtask

   // Press a key from SCAN and leave it held; latency is measured from the
   // edge that first drives the key's row.
   task automatic press(input int code);
      logic [1:0] r, c;
      int n;
      locate(code, r, c);
      wait_row(r, 1'b1);
      hrow = r;
      hcol = c;
      held = 1'b1;
      wait_row(r, 1'b0);
      wait_valid(n);
      check("press_latency", n, LAT);
      check_pulse(code);
   endtask

   task automatic release_key();
      int kv0;
      kv0 = kv_count;
      held = 1'b0;
      repeat (SD * (DB + 3)) @(negedge clk);
      check("no_kv_on_release", kv_count - kv0, 0);
   endtask

   task automatic tap(input int code);
      press(code);
      release_key();
   endtask

   initial begin
      int n, kv0, ov0, er0;
      logic [3:0] exp_row;
      logic [1:0] r, c;

      // 1. reset and idle row rotation
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_key_row", key_row, 4'b1110);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_code", key_code, 0);
      check("rst_entry", entry, 0);
      check("rst_digit_count", digit_count, 0);
      check("rst_operand", operand, 0);
      check("rst_operand_valid", operand_valid, 0);
      check("rst_entry_err", entry_err, 0);
      reset = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         exp_row = ~(4'b0001 << ((i / SD) % 4));
         check("idle_rotation", key_row, exp_row);
      end

      // 2. 1, 2, 8, # -> operand 128
      tap(1);
      tap(2);
      tap(8);
      tap(15);

      // 3. 2, 5, 6 (rejected), # -> operand 25
      tap(2);
      tap(5);
      tap(6);
      tap(15);

      // 4a. bounce on '5': two low ticks, no acceptance
      kv0 = kv_count;
      locate(5, r, c);
      wait_row(r, 1'b1);
      hrow = r;
      hcol = c;
      held = 1'b1;
      wait_row(r, 1'b0);
      repeat (SD * 2 + 1) @(negedge clk);
      held = 1'b0;
      repeat (SD - 2) @(negedge clk);
      check("bounce_row_held", key_row, 4'b1101);
      @(negedge clk);
      check("bounce_row_advanced", key_row, 4'b1011);
      repeat (SD) @(negedge clk);
      check("bounce_row_next", key_row, 4'b0111);
      repeat (SD * 4) @(negedge clk);
      check("bounce_no_key_valid", kv_count - kv0, 0);

      // 4b. long hold on '5' with a one-tick release glitch
      kv0 = kv_count;
      press(5);
      repeat (SD * 20) @(negedge clk);
      held = 1'b0;
      repeat (SD) @(negedge clk);
      held = 1'b1;
      repeat (SD * 25) @(negedge clk);
      release_key();
      check("hold_single_key_valid", kv_count - kv0, 1);

      // 5. clear and ignored keys
      tap(14);
      ov0 = ov_count;
      tap(9);
      tap(9);
      tap(14);
      check("clear_no_operand_valid", ov_count - ov0, 0);
      ov0 = ov_count;
      tap(15);
      check("empty_hash_no_pulse", ov_count - ov0, 0);
      check("empty_hash_operand", operand, m_operand);
      tap(10);

      // 6. reset while held in PRESSED with entry = 7
      tap(14);
      press(7);
      check("pre_reset_entry", entry, 7);
      repeat (SD * 2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_entry = 0;
      m_cnt = 0;
      m_operand = 0;
      check("mid_rst_key_row", key_row, 4'b1110);
      check("mid_rst_key_valid", key_valid, 0);
      check("mid_rst_key_code", key_code, 0);
      check("mid_rst_entry", entry, 0);
      check("mid_rst_digit_count", digit_count, 0);
      check("mid_rst_operand", operand, 0);
      check("mid_rst_operand_valid", operand_valid, 0);
      check("mid_rst_entry_err", entry_err, 0);
      wait_valid(n);
      check("redetect_latency", n, 2 * SD + LAT);
      check_pulse(7);
      release_key();

      // random key sequence against the model
      er0 = er_count;
      for (int k = 0; k < 40; k++) begin
         press(int'($urandom_range(0, 15)));
         repeat ($urandom_range(0, 3) * SD) @(negedge clk);
         release_key();
      end
      check("err_count_sane", (er_count >= er0), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
